rca_pipe_addsub: RTL and testbench

RCA_PIPE_ADDSUB -- requirements
Module: rca_pipe_addsub

---
 rtl/rca_pipe_addsub_if.sv | 27 ++
 rtl/rca_pipe_addsub.sv | 138 +++++++++++++
 tb/tb_rca_pipe_addsub.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rca_pipe_addsub_if.sv
// Handshake and data bundle for the pipelined ripple-carry adder/subtractor.
// The slave modport is the adder side; the master modport is the producer/consumer side.
interface rca_pipe_addsub_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, carry, overflow
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, carry, overflow
    );
endinterface

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: one WIDTH/STAGES-bit slice per stage,
// operand skew on the way in, sum de-skew on the way out, whole-pipe stall on backpressure.
module rca_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic clk,
    input  logic rst,
    rca_pipe_addsub_if.slave bus
);
    localparam int SW = (STAGES >= 1) ? (WIDTH / STAGES) : 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("rca_pipe_addsub: WIDTH must be a positive multiple of STAGES");
    end

    // Chain of SW full adders; returns {carry_out, sum}.
    function automatic logic [SW:0] fa_chain(input logic [SW-1:0] x,
                                             input logic [SW-1:0] y,
                                             input logic          ci);
        logic [SW-1:0] s;
        logic          c;
        c = ci;
        for (int i = 0; i < SW; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    logic             w_stall;
    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Subtraction is a + ~b + 1; the external carry-in only matters for add.
    always_comb begin
        w_b_eff = bus.sub ? ~bus.b : bus.b;
        w_c0    = bus.sub ? 1'b1 : bus.cin;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SW;
        localparam int UP = WIDTH - (k + 1) * SW;

        logic [SW-1:0]    w_a_sl;
        logic [SW-1:0]    w_b_sl;
        logic             w_c_in;
        logic             w_v_in;
        logic [SW:0]      w_res;
        logic [LO+SW-1:0] w_s_next;
        logic             r_v;
        logic             r_c;
        logic [LO+SW-1:0] r_s;

        if (k == 0) begin : g_head
            // First slice takes its bits straight from the accepted operands.
            always_comb begin
                w_a_sl   = bus.a[SW-1:0];
                w_b_sl   = w_b_eff[SW-1:0];
                w_c_in   = w_c0;
                w_v_in   = bus.in_valid;
                w_s_next = w_res[SW-1:0];
            end
        end else begin : g_body
            // Later slices take skewed operands and the carry registered by the previous slice.
            always_comb begin
                w_a_sl   = g_stage[k-1].g_skew.r_a[SW-1:0];
                w_b_sl   = g_stage[k-1].g_skew.r_b[SW-1:0];
                w_c_in   = g_stage[k-1].r_c;
                w_v_in   = g_stage[k-1].r_v;
                w_s_next = {w_res[SW-1:0], g_stage[k-1].r_s};
            end
        end

        assign w_res = fa_chain(w_a_sl, w_b_sl, w_c_in);

        // Stage valid, slice carry and accumulated low sum bits.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_v_in;
                r_c <= w_res[SW];
                r_s <= w_s_next;
            end
        end

        if (UP > 0) begin : g_skew
            logic [UP-1:0] w_a_up;
            logic [UP-1:0] w_b_up;
            logic [UP-1:0] r_a;
            logic [UP-1:0] r_b;

            if (k == 0) begin : g_src
                assign w_a_up = bus.a[WIDTH-1:SW];
                assign w_b_up = w_b_eff[WIDTH-1:SW];
            end else begin : g_src
                assign w_a_up = g_stage[k-1].g_skew.r_a[UP+SW-1:SW];
                assign w_b_up = g_stage[k-1].g_skew.r_b[UP+SW-1:SW];
            end

            // Operand bits not yet consumed ride along with their own operation.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_up;
                    r_b <= w_b_up;
                end
            end
        end

        if (k == STAGES - 1) begin : g_tail
            logic r_ovf;

            // Carry into the MSB is a^b^sum at that bit, so overflow = that XOR carry-out.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_a_sl[SW-1] ^ w_b_sl[SW-1] ^ w_res[SW-1] ^ w_res[SW];
                end
            end
        end
    end

    assign w_stall       = g_stage[STAGES-1].r_v & ~bus.out_ready;
    assign w_adv         = ~w_stall;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = g_stage[STAGES-1].r_v;
    assign bus.sum       = g_stage[STAGES-1].r_s;
    assign bus.carry     = g_stage[STAGES-1].r_c;
    assign bus.overflow  = g_stage[STAGES-1].g_tail.r_ovf;
endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Bench for rca_pipe_addsub: directed vector table, backpressure, random scoreboard,
// mid-stream reset and a single-stage 4-bit instance.
module tb_rca_pipe_addsub;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rca_pipe_addsub_if #(.WIDTH(16)) bus16 ();
    rca_pipe_addsub_if #(.WIDTH(4))  bus4 ();

    rca_pipe_addsub #(.WIDTH(16), .STAGES(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    rca_pipe_addsub #(.WIDTH(4),  .STAGES(1)) u_dut4  (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_s;
        logic        exp_c;
        logic        exp_o;
    } vec_t;

    int   n_checks = 0;
    int   n_err    = 0;
    int   n_pop    = 0;
    res_t exp_q[$];

    function automatic res_t ref16(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic su);
        logic [15:0] be;
        logic [16:0] t;
        res_t        r;
        be  = su ? ~b : b;
        t   = 17'(a) + 17'(be) + (su ? 17'd1 : 17'(ci));
        r.s = t[15:0];
        r.c = t[16];
        r.o = (a[15] == be[15]) && (t[15] != a[15]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic su, input logic rdy);
        bus16.in_valid  = v;
        bus16.a         = a;
        bus16.b         = b;
        bus16.cin       = ci;
        bus16.sub       = su;
        bus16.out_ready = rdy;
    endtask

    task automatic sb_eval();
        res_t e;
        if (bus16.out_valid && bus16.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_unexpected: actual result sum %0h, required no result", bus16.sum);
            end else begin
                e = exp_q.pop_front();
                chk("sb_sum",   32'(bus16.sum),      32'(e.s));
                chk("sb_carry", 32'(bus16.carry),    32'(e.c));
                chk("sb_ovf",   32'(bus16.overflow), 32'(e.o));
                n_pop++;
            end
        end
        if (bus16.in_valid && bus16.in_ready)
            exp_q.push_back(ref16(bus16.a, bus16.b, bus16.cin, bus16.sub));
    endtask

    task automatic sb_cycle(input logic v, input logic rdy);
        drive16(v, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), rdy);
        #1;
        sb_eval();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[9];
        int          pop0;
        int          sent;
        int          stall_left;
        logic [15:0] hs;
        logic        hc;
        logic        ho;

        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vt[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vt[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[7] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vt[8] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst = 1'b0;
        drive16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        bus4.in_valid  = 1'b0;
        bus4.a         = 4'h0;
        bus4.b         = 4'h0;
        bus4.cin       = 1'b0;
        bus4.sub       = 1'b0;
        bus4.out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("rst_sum",       32'(bus16.sum),       32'd0);
        chk("rst_carry",     32'(bus16.carry),     32'd0);
        chk("rst_ovf",       32'(bus16.overflow),  32'd0);
        chk("rst_in_ready",  32'(bus16.in_ready),  32'd1);
        chk("rst4_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst4_sum",       32'(bus4.sum),       32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors: accept on the first edge, result exactly after edge 4.
        for (int i = 0; i < 9; i++) begin
            drive16(1'b1, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, 1'b1);
            tick();
            drive16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            tick();
            tick();
            chk("vec_early_valid", 32'(bus16.out_valid), 32'd0);
            tick();
            chk("vec_valid", 32'(bus16.out_valid), 32'd1);
            chk("vec_sum",   32'(bus16.sum),       32'(vt[i].exp_s));
            chk("vec_carry", 32'(bus16.carry),     32'(vt[i].exp_c));
            chk("vec_ovf",   32'(bus16.overflow),  32'(vt[i].exp_o));
            tick();
        end

        // Eight back-to-back operations with a three-cycle stall once results appear.
        pop0       = n_pop;
        sent       = 0;
        stall_left = -1;
        for (int cyc = 0; cyc < 60 && (n_pop - pop0) < 8; cyc++) begin
            if (stall_left < 0 && bus16.out_valid) stall_left = 3;
            drive16(sent < 8, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                    !(stall_left > 0));
            #1;
            if (stall_left > 0) begin
                chk("bp_in_ready", 32'(bus16.in_ready), 32'd0);
                chk("bp_valid",    32'(bus16.out_valid), 32'd1);
                if (stall_left == 3) begin
                    hs = bus16.sum;
                    hc = bus16.carry;
                    ho = bus16.overflow;
                    if (exp_q.size() > 0) chk("bp_head_sum", 32'(hs), 32'(exp_q[0].s));
                end else begin
                    chk("bp_hold_sum",   32'(bus16.sum),      32'(hs));
                    chk("bp_hold_carry", 32'(bus16.carry),    32'(hc));
                    chk("bp_hold_ovf",   32'(bus16.overflow), 32'(ho));
                end
                stall_left--;
            end
            if (bus16.in_valid && bus16.in_ready) sent++;
            sb_eval();
            tick();
        end
        chk("bp_results", 32'(n_pop - pop0), 32'd8);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Random traffic with bubbles and random backpressure, then drain.
        for (int cyc = 0; cyc < 300; cyc++)
            sb_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        for (int cyc = 0; cyc < 12; cyc++)
            sb_cycle(1'b0, 1'b1);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Single-stage 4-bit instance: one-cycle registered result.
        bus4.in_valid = 1'b1;
        bus4.a        = 4'h9;
        bus4.b        = 4'h8;
        bus4.cin      = 1'b1;
        bus4.sub      = 1'b0;
        tick();
        bus4.in_valid = 1'b0;
        chk("w4_valid", 32'(bus4.out_valid), 32'd1);
        chk("w4_sum",   32'(bus4.sum),       32'd2);
        chk("w4_carry", 32'(bus4.carry),     32'd1);
        chk("w4_ovf",   32'(bus4.overflow),  32'd1);
        tick();
        chk("w4_drop", 32'(bus4.out_valid), 32'd0);

        // Reset between edges with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            drive16(1'b1, 16'($urandom) | 16'h0101, 16'($urandom), 1'b1, 1'b0, 1'b1);
            tick();
        end
        drive16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(bus16.out_valid), 32'd0);
        chk("mid_rst_sum",      32'(bus16.sum),       32'd0);
        chk("mid_rst_carry",    32'(bus16.carry),     32'd0);
        chk("mid_rst_in_ready", 32'(bus16.in_ready),  32'd1);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("post_rst_valid", 32'(bus16.out_valid), 32'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
